// File: rtl/cache_pkg.sv
// cache_pkg: MSI message encodings and the L2 arbiter state type
package cache_pkg;
   localparam logic [3:0] READ     = 4'h1;
   localparam logic [3:0] READX    = 4'h2;
   localparam logic [3:0] UPGR     = 4'h3;
   localparam logic [3:0] TO_S     = 4'h4;
   localparam logic [3:0] TO_E     = 4'h5;
   localparam logic [3:0] UPGR_ACK = 4'h6;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_REPLY,
      DELIVER,
      WAIT_ACK
   } arb_state_type;
endpackage

// File: rtl/msi_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder starting at ptr
module rr_pick
   import cache_pkg::*;
#(
   parameter int N_CORES = 2
) (
   input  logic [N_CORES-1:0]         req,
   input  logic [$clog2(N_CORES)-1:0] ptr,
   output logic [$clog2(N_CORES)-1:0] gnt_id,
   output logic                       any_valid
);
   localparam int IDW = $clog2(N_CORES);

   logic [IDW-1:0] cand;

   // walk from the farthest offset down so the nearest requester wins
   always_comb begin
      gnt_id = '0;
      cand = '0;
      for (int k = N_CORES - 1; k >= 0; k--) begin
         cand = IDW'((int'(ptr) + k) % N_CORES);
         gnt_id = req[cand] ? cand : gnt_id;
      end
      any_valid = |req;
   end
endmodule

// File: rtl/msi_bus_arbiter.sv
// msi_bus_arbiter: round-robin sharing of the L2 request/reply channel among L1 controllers
module msi_bus_arbiter
   import cache_pkg::*;
#(
   parameter int N_CORES = 2,
   parameter int MSG_W   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [N_CORES*MSG_W-1:0]     l1_req,
   input  logic [N_CORES-1:0]           l1_req_valid,
   output logic [N_CORES-1:0]           l1_req_ready,
   output logic [N_CORES*MSG_W-1:0]     l1_reply,
   output logic [N_CORES-1:0]           l1_reply_valid,
   input  logic [N_CORES-1:0]           l1_reply_ready,
   input  logic [N_CORES-1:0]           l1_ack_valid,
   output logic [MSG_W-1:0]             l2_req,
   output logic [$clog2(N_CORES)-1:0]   l2_req_id,
   output logic                         l2_req_valid,
   input  logic                         l2_req_ready,
   input  logic [MSG_W-1:0]             l2_reply,
   input  logic                         l2_reply_valid,
   output logic                         l2_reply_ready,
   output logic                         busy,
   output logic                         err_timeout
);
   localparam int IDW = $clog2(N_CORES);
   localparam int TW  = $clog2(TIMEOUT + 1);

   arb_state_type      state, state_next;
   logic [N_CORES-1:0] slot_valid, slot_valid_next, push, drops, clr;
   logic [MSG_W-1:0]   slot_msg [N_CORES];
   logic [IDW-1:0]     rr_ptr, gnt_id, pick_id;
   logic [MSG_W-1:0]   gnt_msg;
   logic [TW-1:0]      tmo_cnt;
   logic [7:0]         drop_cnt;
   logic [8:0]         drop_sum;
   logic               any_valid, grant, tmo_fire;

   rr_pick #(.N_CORES(N_CORES)) u_pick (
      .req       (slot_valid),
      .ptr       (rr_ptr),
      .gnt_id    (pick_id),
      .any_valid (any_valid)
   );

   assign l2_req    = gnt_msg;
   assign l2_req_id = gnt_id;

   always_comb begin
      push = l1_req_valid & l1_req_ready;
      drops = l1_req_valid & ~l1_req_ready;
      drop_sum = {1'b0, drop_cnt} + 9'($countones(drops));
      grant = state == IDLE && any_valid;
      clr = grant ? N_CORES'(1) << pick_id : '0;
      slot_valid_next = (slot_valid & ~clr) | push;
      tmo_fire = tmo_cnt == TW'(TIMEOUT - 1) &&
                 ((state == WAIT_REPLY && !l2_reply_valid) ||
                  (state == WAIT_ACK && !l1_ack_valid[gnt_id]));
      state_next = state;
      case (state)
         IDLE:       state_next = any_valid ? ISSUE : IDLE;
         ISSUE:      state_next = l2_req_ready ? WAIT_REPLY : ISSUE;
         WAIT_REPLY: state_next = l2_reply_valid ? DELIVER : tmo_fire ? IDLE : WAIT_REPLY;
         DELIVER:    state_next = l1_reply_ready[gnt_id] ? WAIT_ACK : DELIVER;
         WAIT_ACK:   state_next = (l1_ack_valid[gnt_id] || tmo_fire) ? IDLE : WAIT_ACK;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else state <= state_next;
   end

   // strobes are registered from the next state so they are clean flops
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slot_valid <= '0;
         for (int i = 0; i < N_CORES; i++) slot_msg[i] <= '0;
         l1_req_ready <= '0;
         l1_reply <= '0;
         l1_reply_valid <= '0;
         l2_req_valid <= 1'b0;
         l2_reply_ready <= 1'b0;
         busy <= 1'b0;
         err_timeout <= 1'b0;
         rr_ptr <= '0;
         gnt_id <= '0;
         gnt_msg <= '0;
         tmo_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         slot_valid <= slot_valid_next;
         l1_req_ready <= ~slot_valid_next;
         for (int i = 0; i < N_CORES; i++)
            if (push[i]) slot_msg[i] <= l1_req[i*MSG_W +: MSG_W];
         drop_cnt <= drop_sum > 9'd255 ? 8'hFF : drop_sum[7:0];
         if (grant) begin
            gnt_id <= pick_id;
            gnt_msg <= slot_msg[pick_id];
         end
         if (state == WAIT_REPLY && l2_reply_valid)
            for (int i = 0; i < N_CORES; i++)
               l1_reply[i*MSG_W +: MSG_W] <= gnt_id == IDW'(i) ? l2_reply : '0;
         tmo_cnt <= (state == state_next && (state == WAIT_REPLY || state == WAIT_ACK)) ?
                    tmo_cnt + TW'(1) : '0;
         if (tmo_fire) err_timeout <= 1'b1;
         if (state != IDLE && state_next == IDLE)
            rr_ptr <= gnt_id == IDW'(N_CORES - 1) ? '0 : gnt_id + IDW'(1);
         l1_reply_valid <= state_next == DELIVER ? N_CORES'(1) << gnt_id : '0;
         l2_req_valid <= state_next == ISSUE;
         l2_reply_ready <= state_next == WAIT_REPLY;
         busy <= state_next != IDLE;
      end
   end
endmodule

// File: tb/tb_msi_bus_arbiter.sv
// tb_msi_bus_arbiter: directed table and sequence checks for msi_bus_arbiter
module tb_msi_bus_arbiter;
   import cache_pkg::*;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] l1_req;
   logic [1:0] l1_req_valid, l1_req_ready;
   logic [7:0] l1_reply;
   logic [1:0] l1_reply_valid, l1_reply_ready, l1_ack_valid;
   logic [3:0] l2_req;
   logic       l2_req_id;
   logic       l2_req_valid, l2_req_ready;
   logic [3:0] l2_reply;
   logic       l2_reply_valid, l2_reply_ready, busy, err_timeout;

   int n_chk = 0;
   int n_fail = 0;
   int hs_cnt = 0;
   int hs0;

   typedef struct packed {
      logic [1:0] vld;
      logic [7:0] req;
      logic       l2rdy;
      logic       l2rv;
      logic [3:0] l2rep;
      logic [1:0] rrdy;
      logic [1:0] ack;
      logic       e_l2v;
      logic [3:0] e_l2req;
      logic       e_id;
      logic       e_l2rr;
      logic [1:0] e_rv;
      logic [7:0] e_rep;
      logic       e_busy;
      logic [1:0] e_rdy;
   } vec_t;

   vec_t tv [10];

   msi_bus_arbiter #(.N_CORES(2), .MSG_W(4), .TIMEOUT(8)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .l1_req         (l1_req),
      .l1_req_valid   (l1_req_valid),
      .l1_req_ready   (l1_req_ready),
      .l1_reply       (l1_reply),
      .l1_reply_valid (l1_reply_valid),
      .l1_reply_ready (l1_reply_ready),
      .l1_ack_valid   (l1_ack_valid),
      .l2_req         (l2_req),
      .l2_req_id      (l2_req_id),
      .l2_req_valid   (l2_req_valid),
      .l2_req_ready   (l2_req_ready),
      .l2_reply       (l2_reply),
      .l2_reply_valid (l2_reply_valid),
      .l2_reply_ready (l2_reply_ready),
      .busy           (busy),
      .err_timeout    (err_timeout)
   );

   always #5 clock = ~clock;

   always @(posedge clock) if (l2_req_valid && l2_req_ready) hs_cnt <= hs_cnt + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      l1_req = '0;
      l1_req_valid = '0;
      l1_reply_ready = '0;
      l1_ack_valid = '0;
      l2_req_ready = 1'b0;
      l2_reply = '0;
      l2_reply_valid = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic pulse(input logic [1:0] cores, input logic [7:0] msgs);
      l1_req_valid = cores;
      l1_req = msgs;
      step();
      l1_req_valid = '0;
   endtask

   task automatic serve(input int id, input logic [3:0] msg, input logic [3:0] rep, input int stall);
      int n = 0;
      while (l2_req_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("issue_valid", l2_req_valid, 1);
      chk("issue_id", l2_req_id, id);
      chk("issue_msg", l2_req, msg);
      for (int s = 0; s < stall; s++) begin
         step();
         chk("hold_stable", {l2_req_valid, l2_req_id, l2_req}, {1'b1, 1'(id), msg});
      end
      l2_req_ready = 1'b1;
      step();
      l2_req_ready = 1'b0;
      l2_reply_valid = 1'b1;
      l2_reply = rep;
      step();
      l2_reply_valid = 1'b0;
      chk("reply_valid", l1_reply_valid, 32'(1) << id);
      chk("reply_msg", l1_reply[id*4 +: 4], rep);
      l1_reply_ready[id] = 1'b1;
      step();
      l1_reply_ready = '0;
      l1_ack_valid[id] = 1'b1;
      step();
      l1_ack_valid = '0;
      chk("idle_after_ack", busy, 0);
   endtask

   initial begin
      // single read: one row per cycle, outputs checked just after each edge
      tv[0] = '{2'b01, {4'h0, READ}, 1'b0, 1'b0, 4'h0, 2'b00, 2'b00,
                1'b0, 4'h0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 2'b10};
      tv[1] = '{2'b00, 8'h00, 1'b0, 1'b0, 4'h0, 2'b00, 2'b00,
                1'b1, READ, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 2'b11};
      tv[2] = '{2'b00, 8'h00, 1'b1, 1'b0, 4'h0, 2'b00, 2'b00,
                1'b0, READ, 1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 2'b11};
      tv[3] = '{2'b00, 8'h00, 1'b0, 1'b0, 4'h0, 2'b00, 2'b00,
                1'b0, READ, 1'b0, 1'b1, 2'b00, 8'h00, 1'b1, 2'b11};
      tv[4] = tv[3];
      tv[5] = '{2'b00, 8'h00, 1'b0, 1'b1, TO_S, 2'b00, 2'b00,
                1'b0, READ, 1'b0, 1'b0, 2'b01, {4'h0, TO_S}, 1'b1, 2'b11};
      tv[6] = '{2'b00, 8'h00, 1'b0, 1'b0, 4'h0, 2'b00, 2'b00,
                1'b0, READ, 1'b0, 1'b0, 2'b01, {4'h0, TO_S}, 1'b1, 2'b11};
      tv[7] = '{2'b00, 8'h00, 1'b0, 1'b0, 4'h0, 2'b01, 2'b00,
                1'b0, READ, 1'b0, 1'b0, 2'b00, {4'h0, TO_S}, 1'b1, 2'b11};
      tv[8] = '{2'b00, 8'h00, 1'b0, 1'b0, 4'h0, 2'b00, 2'b10,
                1'b0, READ, 1'b0, 1'b0, 2'b00, {4'h0, TO_S}, 1'b1, 2'b11};
      tv[9] = '{2'b00, 8'h00, 1'b0, 1'b0, 4'h0, 2'b00, 2'b01,
                1'b0, READ, 1'b0, 1'b0, 2'b00, {4'h0, TO_S}, 1'b0, 2'b11};

      clear_inputs();
      step();
      step();
      chk("rst_ready", l1_req_ready, 0);
      chk("rst_outs", {busy, l2_req_valid, l1_reply_valid, l2_reply_ready, err_timeout}, 0);
      reset_n = 1'b1;
      step();
      chk("ready_after_rst", l1_req_ready, 2'b11);
      chk("rr_after_rst", dut.rr_ptr, 0);

      for (int i = 0; i < 10; i++) begin
         l1_req_valid = tv[i].vld;
         l1_req = tv[i].req;
         l2_req_ready = tv[i].l2rdy;
         l2_reply_valid = tv[i].l2rv;
         l2_reply = tv[i].l2rep;
         l1_reply_ready = tv[i].rrdy;
         l1_ack_valid = tv[i].ack;
         step();
         chk($sformatf("row%0d", i),
             {l2_req_valid, l2_req, l2_req_id, l2_reply_ready, l1_reply_valid, l1_reply, busy, l1_req_ready},
             {tv[i].e_l2v, tv[i].e_l2req, tv[i].e_id, tv[i].e_l2rr, tv[i].e_rv, tv[i].e_rep, tv[i].e_busy, tv[i].e_rdy});
      end
      clear_inputs();
      chk("rr_after_read", dut.rr_ptr, 1);

      // fairness
      do_reset();
      pulse(2'b11, {READX, READ});
      serve(0, READ, TO_S, 0);
      chk("rr_after_c0", dut.rr_ptr, 1);
      serve(1, READX, TO_E, 0);
      chk("rr_after_c1", dut.rr_ptr, 0);
      pulse(2'b01, {4'h0, UPGR});
      serve(0, UPGR, UPGR_ACK, 0);
      pulse(2'b11, {READ, READX});
      serve(1, READ, TO_S, 0);
      serve(0, READX, TO_E, 0);

      // backpressure
      hs0 = hs_cnt;
      pulse(2'b01, {4'h0, READX});
      serve(0, READX, TO_E, 5);
      chk("one_accept", hs_cnt - hs0, 1);

      // slot full
      do_reset();
      pulse(2'b01, {4'h0, READ});
      pulse(2'b10, {UPGR, 4'h0});
      chk("ready1_low", l1_req_ready[1], 0);
      pulse(2'b10, {READX, 4'h0});
      chk("drop_cnt", dut.drop_cnt, 1);
      serve(0, READ, TO_S, 0);
      serve(1, UPGR, UPGR_ACK, 0);
      step();
      step();
      chk("no_extra_req", {busy, l2_req_valid}, 0);
      chk("slots_empty", l1_req_ready, 2'b11);

      // timeout in WAIT_REPLY
      do_reset();
      pulse(2'b11, {READX, READ});
      step();
      chk("tmo_issue", {l2_req_valid, l2_req_id}, 2'b10);
      l2_req_ready = 1'b1;
      step();
      l2_req_ready = 1'b0;
      for (int c = 0; c < 7; c++) step();
      chk("tmo_before", {err_timeout, dut.state == WAIT_REPLY}, 2'b01);
      step();
      chk("tmo_fire", err_timeout, 1);
      chk("tmo_idle", {busy, dut.state == IDLE}, 2'b01);
      chk("tmo_rr", dut.rr_ptr, 1);
      serve(1, READX, TO_E, 0);
      chk("tmo_sticky", err_timeout, 1);

      // stray ack, then async reset mid-DELIVER
      do_reset();
      pulse(2'b01, {4'h0, READ});
      step();
      l2_req_ready = 1'b1;
      step();
      l2_req_ready = 1'b0;
      l2_reply_valid = 1'b1;
      l2_reply = TO_S;
      step();
      l2_reply_valid = 1'b0;
      l1_reply_ready = 2'b01;
      step();
      l1_reply_ready = '0;
      l1_ack_valid = 2'b10;
      step();
      l1_ack_valid = '0;
      chk("stray_ack", {busy, dut.state == WAIT_ACK}, 2'b11);
      l1_ack_valid = 2'b01;
      step();
      l1_ack_valid = '0;
      chk("ack_idle", {busy, dut.rr_ptr}, 2'b01);
      pulse(2'b10, {READ, 4'h0});
      step();
      l2_req_ready = 1'b1;
      step();
      l2_req_ready = 1'b0;
      l2_reply_valid = 1'b1;
      l2_reply = TO_S;
      step();
      l2_reply_valid = 1'b0;
      chk("deliver_c1", l1_reply_valid, 2'b10);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_valids", {l1_reply_valid, l2_req_valid, l2_reply_ready, busy}, 0);
      chk("async_rst_rr", dut.rr_ptr, 0);
      chk("async_rst_ready", l1_req_ready, 0);
      step();
      reset_n = 1'b1;
      step();
      step();
      chk("post_rst_idle", {busy, l2_req_valid, l1_reply_valid, l1_req_ready}, 5'b00011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
